// File: rtl/lea_pkg.sv
// lea_pkg: shared constants, state encoding and rotate helper for the LEA-128 key schedule
package lea_pkg;
  localparam int LEA_ROUNDS = 24;
  localparam int RK_W = 192;
  localparam int KEY_W = 128;
  localparam logic [31:0] DELTA [4] = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec};
  localparam logic [4:0] T_ROT [4] = '{5'd1, 5'd3, 5'd6, 5'd11};
  typedef enum logic [1:0] {IDLE, GEN, STREAM} state_t;
  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction
endpackage

// File: rtl/lea_ks_round.sv
// lea_ks_round: one combinational LEA-128 key-schedule round update of T0..T3
module lea_ks_round
  import lea_pkg::*;
(
  input  logic [3:0][31:0] t,
  input  logic [4:0]       idx,
  output logic [3:0][31:0] t_next
);
  logic [31:0] d;
  assign d = DELTA[idx[1:0]];
  // 5-bit index arithmetic wraps, giving rotation amounts mod 32 for free
  for (genvar g = 0; g < 4; g++) begin : g_word
    assign t_next[g] = rol32(t[g] + rol32(d, idx + 5'(g)), T_ROT[g]);
  end
endmodule

// File: rtl/lea_rk_sequencer.sv
// lea_rk_sequencer: iterative LEA-128 round-key expansion, one key per cycle on a valid/ready stream
module lea_rk_sequencer
  import lea_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RK_W-1:0]  rk,
  output logic [4:0]       rk_idx,
  output logic             done
);
  state_t state, state_next;
  logic [3:0][31:0] t, t_next, prep;
  logic [4:0] round;
  logic xfer, last, advance;
  for (genvar g = 0; g < 4; g++) begin : g_prep
    assign prep[g] = rol32(key[KEY_W-1-32*g -: 32], 5'd8);
  end
  assign round = state == GEN ? 5'd0 : rk_idx + 5'd1;
  assign xfer = rk_valid && rk_ready;
  assign last = rk_idx == 5'(LEA_ROUNDS - 1);
  assign advance = state == GEN || (state == STREAM && xfer && !last);
  lea_ks_round u_round (.t(t), .idx(round), .t_next(t_next));
  always_comb begin
    busy = state != IDLE;
    state_next = state == IDLE ? (start ? GEN : IDLE) :
                 state == GEN  ? STREAM :
                 (xfer && last) ? IDLE : STREAM;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  // rk is registered so rk_ready never reaches rk or rk_valid combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= '0;
      rk <= '0;
      rk_idx <= '0;
      rk_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == STREAM && xfer && last;
      if (state == IDLE && start) t <= prep;
      else if (advance) begin
        t <= t_next;
        rk <= {t_next[0], t_next[1], t_next[2], t_next[1], t_next[3], t_next[1]};
        rk_idx <= round;
        rk_valid <= 1'b1;
      end else if (state == STREAM && xfer) rk_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lea_rk_sequencer.sv
// tb_lea_rk_sequencer: scoreboard bench comparing the key stream with a reference key schedule
module tb_lea_rk_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, rk_ready, busy, rk_valid, done;
  logic [127:0] key;
  logic [191:0] rk;
  logic [4:0] rk_idx;
  typedef struct {
    logic [4:0]   idx;
    logic [191:0] rk;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0;
  int last_done_cyc = 0, rk0_cyc = 0, gap = 0;
  logic exp_done = 1'b0, stall = 1'b0;
  logic [191:0] hold_rk;
  logic [4:0] hold_idx;
  localparam logic [31:0] D [4] = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec};

  lea_rk_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    return m == 0 ? x : (x << m) | (x >> (32 - m));
  endfunction

  task automatic push_key(input logic [127:0] k);
    logic [31:0] t [4];
    logic [31:0] d;
    for (int j = 0; j < 4; j++) t[j] = rol(k[127-32*j -: 32], 8);
    for (int i = 0; i < 24; i++) begin
      d = D[i % 4];
      t[0] = rol(t[0] + rol(d, i), 1);
      t[1] = rol(t[1] + rol(d, i + 1), 3);
      t[2] = rol(t[2] + rol(d, i + 2), 6);
      t[3] = rol(t[3] + rol(d, i + 3), 11);
      sb.push_back('{5'(i), {t[0], t[1], t[2], t[1], t[3], t[1]}});
    end
  endtask

  task automatic cycle(input int p, input logic s, input logic [127:0] k);
    exp_t e;
    @(negedge clk);
    cyc++;
    chk("done", 192'(done), 192'(exp_done));
    if (done) last_done_cyc = cyc;
    if (stall) begin
      chk("hold_rk", rk, hold_rk);
      chk("hold_idx", 192'(rk_idx), 192'(hold_idx));
    end
    rk_ready = $urandom_range(99) < p;
    start = s;
    key = k;
    #1;
    exp_done = 1'b0;
    stall = rk_valid && !rk_ready;
    hold_rk = rk;
    hold_idx = rk_idx;
    if (rk_valid && rk_ready) begin
      if (sb.size() == 0) chk("sb_empty", 192'(1), 192'(0));
      else begin
        e = sb.pop_front();
        chk("idx", 192'(rk_idx), 192'(e.idx));
        chk("rk", rk, e.rk);
        exp_done = e.idx == 5'd23;
      end
      if (rk_idx == 5'd0) begin
        rk0_cyc = cyc;
        gap = cyc - last_done_cyc;
      end
    end
    if (start && !busy) push_key(key);
  endtask

  task automatic drain(input int p);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 300) begin
      cycle(p, 1'b0, '0);
      n++;
    end
    chk("drain_timeout", 192'(n < 300), 192'(1));
  endtask

  task automatic run_key(input int p, input logic [127:0] k, input logic mid);
    cycle(p, 1'b1, k);
    for (int n = 0; n < 6; n++) cycle(p, 1'b0, '0);
    if (mid) cycle(p, 1'b1, ~k);
    drain(p);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key = '0;
    rk_ready = 1'b0;
    #12;
    chk("rst_busy", 192'(busy), 192'(0));
    chk("rst_valid", 192'(rk_valid), 192'(0));
    chk("rst_done", 192'(done), 192'(0));
    chk("rst_rk", rk, 192'(0));
    chk("rst_idx", 192'(rk_idx), 192'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cycle(100, 1'b1, '0);
    cycle(100, 1'b0, '0);
    chk("gen_no_valid", 192'(rk_valid), 192'(0));
    cycle(100, 1'b0, '0);
    chk("rk0_zero", rk, 192'h87dfd3b7_3efe9dbc_efe9dbc3_3efe9dbc_fa76f0fb_3efe9dbc);
    drain(100);
    chk("rk0_to_done", 192'(last_done_cyc - rk0_cyc), 192'(24));
    for (int n = 0; n < 3; n++) cycle(100, 1'b0, '0);
    for (int i = 0; i < 1000; i++)
      run_key(i % 3 == 0 ? 100 : int'($urandom_range(40, 95)),
              {$urandom, $urandom, $urandom, $urandom}, i % 5 == 0);
    begin : reset_test
      int n = 0;
      cycle(100, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      while (!(rk_valid && rk_idx == 5'd10) && n < 50) begin
        cycle(100, 1'b0, '0);
        n++;
      end
      chk("reach_idx10", 192'(n < 50), 192'(1));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 192'(busy), 192'(0));
      chk("arst_valid", 192'(rk_valid), 192'(0));
      chk("arst_rk", rk, 192'(0));
      chk("arst_idx", 192'(rk_idx), 192'(0));
      sb.delete();
      exp_done = 1'b0;
      stall = 1'b0;
      for (int j = 0; j < 3; j++) cycle(100, 1'b0, '0);
      rst_n = 1'b1;
      for (int j = 0; j < 2; j++) cycle(100, 1'b0, '0);
      run_key(100, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 1'b0);
    end
    begin : back_to_back
      logic [127:0] k2;
      k2 = {$urandom, $urandom, $urandom, $urandom};
      cycle(100, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      for (int n = 0; n < 30; n++) cycle(100, 1'b1, k2);
      drain(100);
      chk("b2b_gap", 192'(gap), 192'(2));
      chk("b2b_sb_empty", 192'(sb.size()), 192'(0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
